exec_cdb_unit: RTL

- Execution stage directly downstream of a reservation station.
- When the station presents a ready operation and the unit is not stalling, the unit takes both 64-bit operands, the 10-bit command and the destination ROB tag.
- It computes the result in one cycle, or over MUL_LATENCY cycles for multiply.
- It requests the common data bus (CDB) and broadcasts {valid, value} with the tag, which feeds the station's issueROBTag_i/issueROBval_i.

---
 rtl/exec_cdb_unit_if.sv | 43 ++++
 rtl/exec_cdb_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/exec_cdb_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : exec_cdb_unit_if
// Purpose  : Bundles the reservation-station issue signals and the CDB
//            request/broadcast signals of the execution unit.
// Ports    : TAG_W sets the ROB tag width.
//            rsReady_i/rsVal1_i/rsVal2_i/rsCommands_i/rsTag_i - issued op
//            flush_i   - discard in-flight op
//            cdbGrant_i - CDB arbiter grant
//            stall_o/cdbReq_o/cdbTag_o/cdbVal_o/busy_o - unit outputs
//            modport master : station/arbiter side
//            modport slave  : execution unit side
// Revision : 1.0 - initial release
// ============================================================================
interface exec_cdb_unit_if #(
  parameter int TAG_W = 6
);
  logic             rsReady_i;
  logic [63:0]      rsVal1_i;
  logic [63:0]      rsVal2_i;
  logic [9:0]       rsCommands_i;
  logic [TAG_W-1:0] rsTag_i;
  logic             flush_i;
  logic             cdbGrant_i;
  logic             stall_o;
  logic             cdbReq_o;
  logic [TAG_W-1:0] cdbTag_o;
  logic [64:0]      cdbVal_o;
  logic             busy_o;

  modport master (
    output rsReady_i, rsVal1_i, rsVal2_i, rsCommands_i, rsTag_i,
    output flush_i, cdbGrant_i,
    input  stall_o, cdbReq_o, cdbTag_o, cdbVal_o, busy_o
  );

  modport slave (
    input  rsReady_i, rsVal1_i, rsVal2_i, rsCommands_i, rsTag_i,
    input  flush_i, cdbGrant_i,
    output stall_o, cdbReq_o, cdbTag_o, cdbVal_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/exec_cdb_unit.sv
`default_nettype none
// ============================================================================
// Module   : exec_cdb_unit
// Purpose  : Execution stage behind a reservation station. Accepts one op
//            when the station is ready and the unit is not stalling,
//            computes a 64-bit result (single cycle, or MUL_LATENCY cycles
//            for MUL) and holds it on the CDB until granted.
// Ports    : clk_i   - clock
//            reset_i - synchronous active-high reset
//            bus     - exec_cdb_unit_if.slave (issue inputs, flush, grant,
//                      stall/busy and CDB broadcast outputs)
// Revision : 1.0 - initial release
// ============================================================================
module exec_cdb_unit #(
  parameter int ROBsize     = 32,
  parameter int ROBsizeLog  = $clog2(ROBsize + 1),
  parameter int MUL_LATENCY = 4
) (
  input  logic           clk_i,
  input  logic           reset_i,
  exec_cdb_unit_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_BCAST = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd7;
  localparam logic [3:0] OP_PASS = 4'd8;

  localparam bit MUL_MULTI = (MUL_LATENCY > 1);
  // The counter only has to hold MUL_LATENCY-1.
  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic [63:0] alu(input logic [3:0]  op,
                                      input logic [63:0] a,
                                      input logic [63:0] b);
    logic [63:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << b[5:0];
      OP_SRL:  r = a >> b[5:0];
      OP_MUL:  r = a * b;
      OP_PASS: r = b;
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [CNT_W-1:0]      counter;
  logic [63:0]           op_a;
  logic [63:0]           op_b;
  logic [63:0]           result;
  logic [ROBsizeLog-1:0] tag;

  logic       stall;
  logic       accept;
  logic [3:0] opcode;
  logic       go_exec;
  logic       counter_done;
  logic       unused_cmd_bits;

  assign opcode          = bus.rsCommands_i[3:0];
  assign unused_cmd_bits = ^bus.rsCommands_i[9:4];
  // MUL only takes the counted path when it needs more than one cycle.
  assign go_exec         = (opcode == OP_MUL) && MUL_MULTI;
  assign counter_done    = (counter == CNT_ONE);
  assign accept          = bus.rsReady_i & ~stall & ~bus.flush_i & ~reset_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = go_exec ? S_EXEC : S_BCAST;
        end
      end
      S_EXEC: begin
        if (counter_done) begin
          state_nxt = S_BCAST;
        end
      end
      S_BCAST: begin
        if (bus.cdbGrant_i) begin
          if (accept) begin
            state_nxt = go_exec ? S_EXEC : S_BCAST;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (bus.flush_i) begin
      state_nxt = S_IDLE;
    end
  end

  // Output logic; CDB fields are forced to zero whenever no request is up.
  always_comb begin
    stall        = bus.flush_i | (state == S_EXEC) |
                   ((state == S_BCAST) & ~bus.cdbGrant_i);
    bus.stall_o  = stall;
    bus.cdbReq_o = (state == S_BCAST);
    bus.cdbTag_o = (state == S_BCAST) ? tag : '0;
    bus.cdbVal_o = (state == S_BCAST) ? {1'b1, result} : 65'd0;
    bus.busy_o   = (state != S_IDLE);
  end

  // Datapath: operand/tag capture, multiply countdown, result register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      counter <= '0;
      op_a    <= 64'd0;
      op_b    <= 64'd0;
      result  <= 64'd0;
      tag     <= '0;
    end else begin
      if (bus.flush_i) begin
        counter <= '0;
      end else if (accept && go_exec) begin
        counter <= CNT_LOAD;
      end else if (state == S_EXEC) begin
        counter <= counter - CNT_ONE;
      end

      if (accept) begin
        op_a <= bus.rsVal1_i;
        op_b <= bus.rsVal2_i;
        tag  <= bus.rsTag_i;
        if (!go_exec) begin
          result <= alu(opcode, bus.rsVal1_i, bus.rsVal2_i);
        end
      end else if ((state == S_EXEC) && counter_done && !bus.flush_i) begin
        result <= op_a * op_b;
      end
    end
  end

endmodule
`default_nettype wire
